// File: rtl/axis_chirp_window.sv
// rtl/axis_chirp_window.sv - per-bin amplitude window for chirp frames ahead of the FFT
module axis_chirp_window #(
  parameter int DATA_WIDTH = 16,
  parameter int USER_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int NFFT_MAX   = 12
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [4:0]            cfg_nfft,
  input  logic                  coef_wen,
  input  logic [NFFT_MAX-1:0]   coef_waddr,
  input  logic [COEF_WIDTH-1:0] coef_wdata,
  input  logic                  err_clr,
  output logic                  err_frame,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic [USER_WIDTH-1:0] s_tuser,
  input  logic                  s_tlast,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [USER_WIDTH-1:0] m_tuser,
  output logic                  m_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready
);

  localparam int PW    = DATA_WIDTH + COEF_WIDTH + 1;
  localparam int DEPTH = 1 << NFFT_MAX;
  localparam logic signed [PW-1:0] ROUND_HALF = PW'(1) <<< (COEF_WIDTH - 1);

  logic [COEF_WIDTH-1:0] coef_ram [0:DEPTH-1];

  logic                  en;
  logic                  accept;
  logic [NFFT_MAX-1:0]   idx;
  logic [4:0]            nfft_q;
  logic [4:0]            nfft_cfg;
  logic [4:0]            nfft_cur;
  logic [NFFT_MAX-1:0]   last_idx;
  logic                  at_last;
  logic                  frame_err;

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [USER_WIDTH-1:0] s1_user;
  logic                  s1_last;
  logic [COEF_WIDTH-1:0] coef_q;

  logic                  s2_valid;
  logic signed [PW-1:0]  s2_prod;
  logic [USER_WIDTH-1:0] s2_user;
  logic                  s2_last;

  // One enable freezes the whole pipe, so bubbles stay where they are.
  assign en       = !m_tvalid || m_tready;
  assign s_tready = en;
  assign accept   = s_tvalid && en;

  // Frame length is taken from cfg_nfft only on the first beat of a frame.
  assign nfft_cfg  = (cfg_nfft > 5'(NFFT_MAX)) ? 5'(NFFT_MAX) : cfg_nfft;
  assign nfft_cur  = (idx == '0) ? nfft_cfg : nfft_q;
  // Shifting all-ones left by the frame log2 and inverting gives 2^n - 1,
  // saturating at all-ones for n >= NFFT_MAX.
  assign last_idx  = ~({NFFT_MAX{1'b1}} << nfft_cur);
  assign at_last   = (idx == last_idx);
  assign frame_err = s_tlast != at_last;

  // Coefficient write port; writes land regardless of stall state.
  always_ff @(posedge aclk) begin
    if (coef_wen) begin
      coef_ram[coef_waddr] <= coef_wdata;
    end
  end

  // S1 coefficient read; a same-cycle write to idx returns the old word.
  always_ff @(posedge aclk) begin
    if (en) begin
      coef_q <= coef_ram[idx];
    end
  end

  // In-frame position counter and latched frame length.
  always_ff @(posedge aclk) begin
    if (areset) begin
      idx    <= '0;
      nfft_q <= nfft_cfg;
    end else if (accept) begin
      if (idx == '0) begin
        nfft_q <= nfft_cfg;
      end
      idx <= (s_tlast || at_last) ? '0 : idx + NFFT_MAX'(1);
    end
  end

  // Sticky frame-length error; a new error wins over a same-cycle clear.
  always_ff @(posedge aclk) begin
    if (areset) begin
      err_frame <= 1'b0;
    end else if (accept && frame_err) begin
      err_frame <= 1'b1;
    end else if (err_clr) begin
      err_frame <= 1'b0;
    end
  end

  // Stage payload registers (S1 capture, S2 multiply); no reset needed.
  always_ff @(posedge aclk) begin
    if (en) begin
      s1_data <= s_tdata;
      s1_user <= s_tuser;
      s1_last <= s_tlast;
      s2_prod <= $signed({{(PW-DATA_WIDTH){s1_data[DATA_WIDTH-1]}}, s1_data})
               * $signed({{(PW-COEF_WIDTH){1'b0}}, coef_q});
      s2_user <= s1_user;
      s2_last <= s1_last;
    end
  end

  // Stage valids and S3 output register with round-half-up scaling.
  always_ff @(posedge aclk) begin
    if (areset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tdata  <= '0;
      m_tuser  <= '0;
    end else if (en) begin
      s1_valid <= s_tvalid;
      s2_valid <= s1_valid;
      m_tvalid <= s2_valid;
      m_tlast  <= s2_last;
      m_tuser  <= s2_user;
      m_tdata  <= DATA_WIDTH'((s2_prod + ROUND_HALF) >>> COEF_WIDTH);
    end
  end

endmodule

// File: doc/axis_chirp_window.md
Name: axis_chirp_window

Overview:
- Applies a per-bin amplitude window to each chirp frame before the FFT.
- Sits directly downstream of the chirp framer and consumes its AXI-Stream frames: data, per-beat tuser, tlast at end of frame.
- Window coefficients sit in an internal RAM that software loads through a simple write port.
- The block multiplies each sample by the coefficient at its in-frame position, rounds, and forwards data, tuser and tlast with fixed latency.

Parameters:
DATA_WIDTH, 16, sample width; signed two's complement in and out
USER_WIDTH, 16, tuser width; passed through unchanged
COEF_WIDTH, 16, coefficient width; unsigned fraction, value = coef / 2^COEF_WIDTH
NFFT_MAX, 12, log2 of max frame length; coefficient RAM depth = 2^NFFT_MAX

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-high reset
cfg_nfft  in  5  log2 frame length
coef_wen  in  1  coefficient write strobe
coef_waddr  in  NFFT_MAX  coefficient write address
coef_wdata  in  COEF_WIDTH  coefficient write data
err_clr  in  1  clears err_frame
err_frame  out  1  sticky frame-length mismatch flag
s_tdata  in  DATA_WIDTH  input sample
s_tuser  in  USER_WIDTH  input sideband
s_tlast  in  1  last sample of frame
s_tvalid  in  1  input valid
s_tready  out  1  input ready
m_tdata  out  DATA_WIDTH  windowed sample
m_tuser  out  USER_WIDTH  delayed s_tuser
m_tlast  out  1  delayed s_tlast
m_tvalid  out  1  output valid
m_tready  in  1  output ready

Behaviour:
- Reset (areset high at a clock edge):
  - m_tvalid, m_tlast, err_frame, all stage valids and idx clear to 0.
  - m_tdata and m_tuser clear to 0.
  - nfft_q = min(cfg_nfft, NFFT_MAX).
  - Coefficient RAM contents are not reset.
  - Reset mid-frame discards all in-flight beats; the next accepted beat is index 0.
- Pipeline:
  - Three stages: S1 RAM read at idx, S2 multiply, S3 output register.
  - Global enable en = !m_tvalid || m_tready; s_tready = en.
  - When en is 0, every stage holds its contents.
  - Latency is 3 cycles from acceptance (s_tvalid && s_tready) to m_tvalid, with m_tready held high.
  - Full throughput: one beat per cycle.
  - Bubbles are propagated, not collapsed.
- Index counter idx (NFFT_MAX bits), on each accepted beat:
  - If idx == 0, latch nfft_q = min(cfg_nfft, NFFT_MAX); cfg_nfft changes mid-frame are ignored.
  - If s_tlast, or idx == 2^nfft_q − 1, set idx to 0 on the next cycle; otherwise increment idx.
- err_frame is set on an accepted beat when either holds:
  - s_tlast = 1 and idx != 2^nfft_q − 1 (short frame);
  - idx == 2^nfft_q − 1 and s_tlast = 0 (long or missing tlast).
- err_frame clearing:
  - It stays set until err_clr or reset.
  - If err_clr and a new error occur in the same cycle, the set wins.
  - err_frame does not stall or alter the data path.
- Arithmetic:
  - p = signed(s_tdata) × unsigned(coef), held as a (DATA_WIDTH+COEF_WIDTH+1)-bit signed value.
  - m_tdata = (p + 2^(COEF_WIDTH−1)) >>> COEF_WIDTH (arithmetic shift), truncated to DATA_WIDTH.
  - Coefficients are below 1.0, so no saturation is needed.
- Coefficient RAM:
  - Single write port, single registered read port.
  - A write and an S1 read to the same address in the same cycle returns the old value (read-first).
  - Writes are accepted at any time, including while stalled.
- tuser and tlast travel with their sample through all three stages unchanged.

Test Plan:
- Load coef[i] = 0x8000 for all i, cfg_nfft = 4, m_tready = 1; send 16 beats of s_tdata = 100 with tlast on beat 15 → m_tdata = 50 on every beat; m_tlast only on output beat 15; first m_tvalid 3 cycles after first acceptance; err_frame = 0.
- Load coef[i] = i·4096 (nfft = 4); send s_tdata = −1000 for 16 beats → m_tdata[i] = round(−1000·i/16), e.g. beat 1 = −62, beat 15 = −937. Also check s_tdata = −32768 with coef = 0xFFFF → −32767.
- With a 16-beat frame streaming, toggle m_tready 1,0,0,1,… pseudo-randomly → s_tready mirrors the enable; no beat is lost or duplicated; the output sequence and tuser values (0..15) match the ideal model.
- Short frame: tlast on beat 9 with cfg_nfft = 4 → err_frame = 1 one cycle after that acceptance; the next beat uses coef[0]. Then pulse err_clr → err_frame = 0.
- Long frame: 20 beats, no tlast, cfg_nfft = 4 → err_frame set at beat 15; beats 16–19 use coef[0..3].
- Assert areset for one cycle mid-frame (idx = 7, pipeline full) → m_tvalid = 0 the next cycle; the next accepted beat uses coef[0]; coefficients unchanged. Also set cfg_nfft = 15 → frame length is clamped to 4096.
